reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Central reset controller for the Milkymist SoC. It arbitrates reset requests from the board button, a CSR soft-reset strobe and the watchdog, and records which sources caused the last reset. It then releases the domain resets in a fixed order: Flash first, then peripherals (AC97, video-in), then the CPU/system reset. This ordering lets the Flash leave reset before the CPU starts fetching from it.

## Interface
Parameters:
- HOLD_CYCLES, 16, minimum cycles all resets stay asserted after the last active request
- FLASH_DELAY, 128, cycles between Flash release and peripheral release (covers the 150 ns reset-to-read time)
- PERIPH_DELAY, 16, cycles between peripheral release and CPU release
- CNT_W, 8, delay counter width; each delay parameter must lie in 1..2^CNT_W

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  power-on reset, asynchronous assert, active-low; deassertion is pre-synchronized to sys_clk
- req_button  in  1  raw push-button level, asynchronous, active-high
- req_soft  in  1  CSR soft-reset strobe, sys_clk domain, one-cycle pulse
- req_wdt  in  1  watchdog expiry strobe, sys_clk domain, one-cycle pulse
- cause_clr  in  1  clears the cause register (honoured in RUN only)
- flash_rst_n  out  1  Flash reset, active-low
- periph_rst_n  out  1  AC97/video-in reset, active-low
- cpu_rst  out  1  system/CPU reset, active-high
- busy  out  1  high whenever state is not RUN
- cause  out  4  sticky reset cause: [0] power-on, [1] button, [2] soft, [3] watchdog

## Operation
- req_button passes through a 2-FF synchronizer, giving btn_s. No edge detection: btn_s high is a continuous request.
- req = btn_s | req_soft | req_wdt.
- States: ASSERT, FLASH_WAIT, PERIPH_WAIT, RUN. Single counter cnt[CNT_W-1:0].
- ASSERT: all resets asserted. cnt increments each cycle. At cnt == HOLD_CYCLES-1 with no req, go to FLASH_WAIT and set cnt = 0.
- FLASH_WAIT: flash_rst_n = 1. At cnt == FLASH_DELAY-1, go to PERIPH_WAIT and set cnt = 0.
- PERIPH_WAIT: periph_rst_n = 1 as well. At cnt == PERIPH_DELAY-1, go to RUN.
- RUN: all resets released, busy = 0. cnt holds.
- req high in any state, including ASSERT: go to ASSERT and set cnt = 0. Holding btn_s high therefore holds the system in reset indefinitely.
- Cause register:
  - On any req, cause is ORed with {req_wdt, req_soft, btn_s, 0}. Simultaneous sources are all recorded.
  - Previous bits are kept until cleared.
  - cause_clr clears cause to 0 only when in RUN and req is low. If req and cause_clr occur in the same cycle, req wins and cause_clr is ignored.
- All outputs are registered and updated on the same edge as the state. No combinational path from any input to any output.

## Timing
- Async reset (sys_rst_n low) values: state = ASSERT, cnt = 0, flash_rst_n = 0, periph_rst_n = 0, cpu_rst = 1, busy = 1, cause = 4'b0001, synchronizer = 0.
- Edge 1 is the first sys_clk rising edge with sys_rst_n high.
- With no requests, after edge N:
  - flash_rst_n rises at N = HOLD_CYCLES.
  - periph_rst_n rises at N = HOLD_CYCLES + FLASH_DELAY.
  - cpu_rst falls and busy falls at N = HOLD_CYCLES + FLASH_DELAY + PERIPH_DELAY.
  - Defaults: 16 / 144 / 160.
- req_soft or req_wdt sampled high at edge t: all resets are asserted after edge t, and the release sequence restarts from edge t+1.
- req_button latency: 2 edges (synchronizer), then the same behaviour as above.
- Back-to-back strobes during ASSERT extend the hold. A strobe during FLASH_WAIT or PERIPH_WAIT re-asserts already-released resets on the next edge.
- sys_rst_n asserted mid-sequence forces the reset values immediately (asynchronous). cause returns to 4'b0001 and earlier cause bits are lost.
- Counter compare is exact equality at parameter-1. The counter never wraps for legal parameter values.

## Test plan
- Power-on, defaults, no requests -> flash_rst_n rises after edge 16, periph_rst_n after edge 144, cpu_rst/busy fall after edge 160; cause = 4'b0001.
- In RUN, pulse cause_clr and then req_wdt -> cause 0 after the clear; after the strobe, all resets asserted on the next edge, cause = 4'b1000, cpu_rst falls 160 edges later.
- req_soft pulsed in PERIPH_WAIT -> periph_rst_n and flash_rst_n drop on the next edge; the full 160-cycle sequence restarts; cause bit 2 set.
- req_button held for 500 cycles, then released -> state stays ASSERT throughout; flash_rst_n rises HOLD_CYCLES+2 edges after release; cause bit 1 set.
- req_soft and req_wdt in the same cycle as cause_clr during RUN -> cause = prior | 4'b1100 (clear ignored); sequence restarts.
- sys_rst_n pulsed low during FLASH_WAIT after a watchdog reset -> outputs immediately return to reset values, cause = 4'b0001, power-on timing repeats.

Source files
------------

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - arbitrates reset requests and releases Flash, peripheral and CPU resets in order
module reset_sequencer #(
    parameter int HOLD_CYCLES  = 16,
    parameter int FLASH_DELAY  = 128,
    parameter int PERIPH_DELAY = 16,
    parameter int CNT_W        = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       req_button,
    input  logic       req_soft,
    input  logic       req_wdt,
    input  logic       cause_clr,
    output logic       flash_rst_n,
    output logic       periph_rst_n,
    output logic       cpu_rst,
    output logic       busy,
    output logic [3:0] cause
);

    typedef enum logic [1:0] {
        ASSERT      = 2'd0,
        FLASH_WAIT  = 2'd1,
        PERIPH_WAIT = 2'd2,
        RUN         = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             flash_rst_n_q;
    logic             periph_rst_n_q;
    logic             cpu_rst_q;
    logic             busy_q;
    logic [3:0]       cause_q;
    logic             btn_meta_q;
    logic             btn_s_q;
    logic             req;

    // The button is a raw asynchronous level, so it gets two flops before use.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
        end else begin
            btn_meta_q <= req_button;
            btn_s_q    <= btn_meta_q;
        end
    end

    assign req = btn_s_q | req_soft | req_wdt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= ASSERT;
            cnt_q          <= '0;
            flash_rst_n_q  <= 1'b0;
            periph_rst_n_q <= 1'b0;
            cpu_rst_q      <= 1'b1;
            busy_q         <= 1'b1;
        end else if (req) begin
            state_q        <= ASSERT;
            cnt_q          <= '0;
            flash_rst_n_q  <= 1'b0;
            periph_rst_n_q <= 1'b0;
            cpu_rst_q      <= 1'b1;
            busy_q         <= 1'b1;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q       <= FLASH_WAIT;
                        cnt_q         <= '0;
                        flash_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                FLASH_WAIT: begin
                    if (cnt_q == FLASH_LAST) begin
                        state_q        <= PERIPH_WAIT;
                        cnt_q          <= '0;
                        periph_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PERIPH_WAIT: begin
                    if (cnt_q == PERIPH_LAST) begin
                        state_q   <= RUN;
                        cpu_rst_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Cause bits are sticky; a request in the same cycle as a clear takes priority.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cause_q <= 4'b0001;
        end else if (req) begin
            cause_q <= cause_q | {req_wdt, req_soft, btn_s_q, 1'b0};
        end else if (cause_clr && state_q == RUN) begin
            cause_q <= 4'b0000;
        end
    end

    assign flash_rst_n  = flash_rst_n_q;
    assign periph_rst_n = periph_rst_n_q;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign cause        = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer output transitions
module tb_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_button = 1'b0;
    logic       req_soft = 1'b0;
    logic       req_wdt = 1'b0;
    logic       cause_clr = 1'b0;
    logic       flash_rst_n;
    logic       periph_rst_n;
    logic       cpu_rst;
    logic       busy;
    logic [3:0] cause;

    int   edge_n = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    reset_sequencer dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .req_button   (req_button),
        .req_soft     (req_soft),
        .req_wdt      (req_wdt),
        .cause_clr    (cause_clr),
        .flash_rst_n  (flash_rst_n),
        .periph_rst_n (periph_rst_n),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .cause        (cause)
    );

    always #5 clk = ~clk;

    // Edge numbering restarts at every reset so expected times read like the timing table.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    function automatic logic [7:0] outs();
        return {flash_rst_n, periph_rst_n, cpu_rst, busy, cause};
    endfunction

    task automatic expect_at(input int cyc, input logic [7:0] val);
        exp_t e;
        e.cyc = cyc;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drive_at(input int n);
        while (edge_n < n - 1) @(negedge clk);
        #1;
    endtask

    task automatic pulse(input int n, input logic s, input logic w, input logic c);
        drive_at(n);
        req_soft  = s;
        req_wdt   = w;
        cause_clr = c;
        @(negedge clk);
        #1;
        req_soft  = 1'b0;
        req_wdt   = 1'b0;
        cause_clr = 1'b0;
    endtask

    task automatic run_monitor();
        logic [8:0] prev;
        logic [7:0] cur;
        exp_t       e;
        prev = 9'h100;
        forever begin
            @(negedge clk);
            cur = outs();
            if ({1'b0, cur} !== prev) begin
                prev = {1'b0, cur};
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change edge=%0d got=%h required=no change", edge_n, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc == edge_n && e.val === cur)
                        n_pass++;
                    else
                        $display("FAIL transition got edge=%0d val=%h required edge=%0d val=%h",
                                 edge_n, cur, e.cyc, e.val);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout edge=%0d required=finish", edge_n);
        $fatal(1, "bench timeout");
    end

    initial begin
        fork
            run_monitor();
        join_none

        // Power-on with defaults
        expect_at(0, 8'h31);
        expect_at(16, 8'hB1);
        expect_at(144, 8'hF1);
        expect_at(160, 8'hC1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Clear in RUN, then watchdog strobe
        expect_at(170, 8'hC0);
        pulse(170, 1'b0, 1'b0, 1'b1);
        expect_at(171, 8'h38);
        expect_at(187, 8'hB8);
        expect_at(315, 8'hF8);
        expect_at(331, 8'hC8);
        pulse(171, 1'b0, 1'b1, 1'b0);

        // Soft reset, clear attempted outside RUN, soft reset again in PERIPH_WAIT
        expect_at(335, 8'hC0);
        pulse(335, 1'b0, 1'b0, 1'b1);
        expect_at(336, 8'h34);
        expect_at(352, 8'hB4);
        expect_at(480, 8'hF4);
        pulse(336, 1'b1, 1'b0, 1'b0);
        pulse(366, 1'b0, 1'b0, 1'b1);
        expect_at(486, 8'h34);
        expect_at(502, 8'hB4);
        expect_at(630, 8'hF4);
        expect_at(646, 8'hC4);
        pulse(486, 1'b1, 1'b0, 1'b0);

        // Button held for 500 cycles
        expect_at(652, 8'h36);
        drive_at(650);
        req_button = 1'b1;
        expect_at(1167, 8'hB6);
        expect_at(1295, 8'hF6);
        expect_at(1311, 8'hC6);
        drive_at(1150);
        req_button = 1'b0;

        // Soft + watchdog + clear together in RUN
        expect_at(1315, 8'h3E);
        expect_at(1331, 8'hBE);
        expect_at(1459, 8'hFE);
        expect_at(1475, 8'hCE);
        pulse(1315, 1'b1, 1'b1, 1'b1);

        // Watchdog, then power-on reset during FLASH_WAIT
        expect_at(1480, 8'h3E);
        expect_at(1496, 8'hBE);
        pulse(1480, 1'b0, 1'b1, 1'b0);
        drive_at(1530);
        expect_at(0, 8'h31);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (outs() === 8'h31) n_pass++;
        else $display("FAIL async_reset got=%h required=31", outs());
        expect_at(16, 8'hB1);
        expect_at(144, 8'hF1);
        expect_at(160, 8'hC1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        drive_at(170);

        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_total++;
            $display("FAIL missing_transition got=none required edge=%0d val=%h", e.cyc, e.val);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
